// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard (device-side) transmitter: 4-deep scan-code FIFO feeding an 11-bit frame serialiser.
// Optional macro PS2_TX_BREAK_EN: a byte offered with in_release = 1 is queued as 0xF0 then the code.
module ps2_kbd_tx #(
    parameter int unsigned HALF_PERIOD = 50,
    parameter int unsigned IDLE_GAP    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_code,
    input  logic       in_release,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [7:0] HP_LOAD  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LOAD = 8'(IDLE_GAP - 1);

    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [10:0] frame_q, frame_d;
    logic        ps2_clk_q, ps2_clk_d;
    logic        ps2_data_q, ps2_data_d;
    logic [7:0]  sent_q, sent_d;

    logic        push_two;
    logic        accept;
    logic [2:0]  push_n;
    logic        pop;
    logic [7:0]  head;
    logic [10:0] load_frame;

`ifdef PS2_TX_BREAK_EN
    assign push_two = in_release;
`else
    logic unused_release;
    assign unused_release = in_release;
    assign push_two       = 1'b0;
`endif

    // Readiness looks only at the current level, never at a same-cycle pop.
    assign in_ready = push_two ? (level_q <= 3'd2) : (level_q <= 3'd3);
    assign accept   = in_valid && in_ready;
    assign push_n   = accept ? (push_two ? 3'd2 : 3'd1) : 3'd0;

    // A waiting byte is popped from IDLE, or on the last gap cycle so the idle gap is exact.
    assign pop = (level_q != 3'd0) &&
                 ((state_q == S_IDLE) || ((state_q == S_GAP) && (cnt_q == 8'd0)));

    assign head       = mem[rd_ptr_q];
    assign load_frame = {1'b1, ~^head, head, 1'b0};

    always_comb begin
        wr_ptr_d = wr_ptr_q + push_n[1:0];
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        level_d  = level_q + push_n - {2'b00, pop};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        sent_d     = sent_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d    = S_HI;
                    cnt_d      = HP_LOAD;
                    bit_d      = 4'd0;
                    frame_d    = load_frame;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = load_frame[0];
                end
            end
            S_HI: begin
                if (cnt_q == 8'd0) begin
                    state_d   = S_LO;
                    cnt_d     = HP_LOAD;
                    ps2_clk_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_LO: begin
                if (cnt_q == 8'd0) begin
                    ps2_clk_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        state_d    = S_GAP;
                        cnt_d      = GAP_LOAD;
                        ps2_data_d = 1'b1;
                        sent_d     = sent_q + 8'd1;
                    end else begin
                        state_d    = S_HI;
                        cnt_d      = HP_LOAD;
                        bit_d      = bit_q + 4'd1;
                        frame_d    = {1'b0, frame_q[10:1]};
                        ps2_data_d = frame_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    if (pop) begin
                        state_d    = S_HI;
                        cnt_d      = HP_LOAD;
                        bit_d      = 4'd0;
                        frame_d    = load_frame;
                        ps2_data_d = load_frame[0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            level_q    <= 3'd0;
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 4'd0;
            frame_q    <= 11'h7FF;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            sent_q     <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            sent_q     <= sent_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (push_two) begin
                mem[wr_ptr_q]        <= 8'hF0;
                mem[wr_ptr_q + 2'd1] <= in_code;
            end else begin
                mem[wr_ptr_q] <= in_code;
            end
        end
    end

    assign ps2_clk     = ps2_clk_q;
    assign ps2_data    = ps2_data_q;
    assign busy        = (state_q != S_IDLE) || (level_q != 3'd0);
    assign frames_sent = sent_q;

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter HALF_PERIOD, default 50, clk cycles per ps2_clk half-period (high or low); legal range 2..255.
REQ-002 Parameter IDLE_GAP, default 100, clk cycles of line idle (both lines 1) between consecutive frames; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  scan-code byte offered.
REQ-006 in_code  in  8  scan-code byte.
REQ-007 in_release  in  1  byte is a key release (used only when PS2_TX_BREAK_EN is defined).
REQ-008 in_ready  out  1  byte accepted on posedge where in_valid && in_ready.
REQ-009 ps2_clk  out  1  PS/2 clock, device-driven, idle 1.
REQ-010 ps2_data  out  1  PS/2 data, device-driven, idle 1.
REQ-011 busy  out  1  frame or inter-frame gap in progress, or FIFO non-empty.
REQ-012 frames_sent  out  8  count of completed frames, wraps 255->0.

Function
REQ-013 4-entry x 8-bit FIFO, in-order; simultaneous push and pop in one cycle SHALL both occur; level never exceeds 4.
REQ-014 Frame = 11 bits: start 0, in_code[0]..in_code[7] (LSB first), odd parity (~^byte), stop 1.
REQ-015 FSM states IDLE, HI, LO, GAP; IDLE->HI when FIFO non-empty (pop, load frame, ps2_data = start bit, ps2_clk = 1).
REQ-016 HI: ps2_clk = 1 for HALF_PERIOD cycles, ps2_data stable at current bit; then ->LO.
REQ-017 LO: ps2_clk = 0 for HALF_PERIOD cycles, ps2_data unchanged; then next bit ->HI (ps2_data updated on same edge ps2_clk rises), or after stop bit ->GAP.
REQ-018 ps2_data SHALL change only while ps2_clk = 1; receiver samples on ps2_clk falling edge; frame length exactly 22*HALF_PERIOD cycles.
REQ-019 frames_sent SHALL increment on the LO->GAP transition.
REQ-020 GAP: both lines 1 for IDLE_GAP cycles, then ->IDLE; IDLE with FIFO non-empty proceeds to HI on next edge.
REQ-021 Latency: byte accepted at edge N into empty FIFO with FSM in IDLE -> start bit driven from edge N+1; first ps2_clk falling edge at edge N+1+HALF_PERIOD.
REQ-022 in_ready = free entries >= 1 (>= 2 when in_release && PS2_TX_BREAK_EN); evaluated from current level only, not same-cycle pop.
REQ-023 in_code = 0x00 SHALL be transmitted normally (parity 1).

Reset
REQ-024 rst low SHALL immediately force ps2_clk = 1, ps2_data = 1, busy = 0, frames_sent = 0, FSM = IDLE, FIFO empty; in_ready = 1 once rst is high.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no further ps2_clk edges; no partial frame resumes after release.

Configuration
REQ-026 Macro PS2_TX_BREAK_EN defined: accepted byte with in_release = 1 pushes 0xF0 then in_code (two entries, same cycle); in_release = 0 pushes in_code only.
REQ-027 PS2_TX_BREAK_EN undefined: in_release ignored, every accept pushes exactly one entry, in_ready = free entries >= 1.

Verification (HALF_PERIOD = 4, IDLE_GAP = 8)
REQ-028 Reset: rst low mid-run -> ps2_clk = 1, ps2_data = 1, busy = 0, frames_sent = 0 same cycle; after release in_ready = 1.
REQ-029 Send 0x1C -> ps2_data at 11 ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1; frame 88 cycles; frames_sent = 1; lines idle >= 8 cycles after.
REQ-030 BREAK_EN, in_release = 1, in_code = 0x1C -> frame 0xF0 (parity 1) then frame 0x1C (parity 0), gap exactly 8 cycles idle between; frames_sent = 2.
REQ-031 Push 0x01..0x06 on consecutive cycles -> 0x01..0x05 accepted (first popped next cycle), in_ready = 0 holding 0x06 until pop of 0x02 after frame 1 + gap; six frames in order.
REQ-032 Assert rst after 5th ps2_clk falling edge -> both lines 1 immediately, FIFO empty; after release, zero ps2_clk edges with in_valid = 0.
REQ-033 Send 256 frames -> frames_sent reads 0xFF after frame 255, 0x00 after frame 256.
